// File: rtl/uart_feed_pkg.sv
// Shared types and helpers for the UART transmit feeder.
// Latency: none (declarations only).
// Backpressure: n/a.
package uart_feed_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POP       = 3'd1,
    SEND      = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } feed_state_t;

  // Pointer width for a power-of-two FIFO; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Synchronous byte FIFO with exact occupancy count and registered read data.
// Latency: a write is visible on o_Empty/o_Level the cycle after its edge; read data lands on the pop edge.
// Backpressure: writes while full are dropped and flagged by a one-cycle o_Overflow pulse.
module sync_byte_fifo
  import uart_feed_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     i_Rst,
  input  logic                     i_Wr_DV,
  input  logic [BYTE_W-1:0]        i_Wr_Byte,
  input  logic                     i_Pop,
  output logic [BYTE_W-1:0]        o_Rd_Byte,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic [$clog2(DEPTH):0]   o_Level,
  output logic                     o_Overflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  assign o_Full  = (o_Level == LW'(DEPTH));
  assign o_Empty = (o_Level == '0);
  assign wr_ok   = i_Wr_DV & ~o_Full;
  assign rd_ok   = i_Pop & ~o_Empty;

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[wr_ptr] <= i_Wr_Byte;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; level tracks the exact count.
  always_ff @(posedge CLK) begin
    if (i_Rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_Level    <= '0;
      o_Rd_Byte  <= '0;
      o_Overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_ok) begin
        rd_ptr    <= rd_ptr + PW'(1);
        o_Rd_Byte <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   o_Level <= o_Level + LW'(1);
        2'b01:   o_Level <= o_Level - LW'(1);
        default: o_Level <= o_Level;
      endcase
      o_Overflow <= i_Wr_DV & o_Full;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and issues them one at a time to a UART transmitter.
// Latency: write accepted at edge N into an idle, empty feeder strobes o_TX_DV in the cycle after edge N+2.
// Backpressure: waits for i_TX_Active low before each pop and for a Done rising edge after each strobe.
// Optional: define UART_FEED_GAP_EN to insert GAP_CLKS idle cycles after every completed frame.
module uart_tx_feeder
  import uart_feed_pkg::*;
#(
  parameter int DEPTH = 16
`ifdef UART_FEED_GAP_EN
  , parameter int GAP_CLKS = 16
`endif
) (
  input  logic                   CLK,
  input  logic                   i_Rst,
  input  logic                   i_Wr_DV,
  input  logic [7:0]             i_Wr_Byte,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [$clog2(DEPTH):0] o_Level,
  output logic                   o_Overflow,
  output logic                   o_TX_DV,
  output logic [7:0]             o_TX_Byte,
  input  logic                   i_TX_Active,
  input  logic                   i_TX_Done,
  output logic                   o_Busy
);

  feed_state_t state_q;
  feed_state_t state_nxt;
  logic        done_q;
  logic        done_rise;
  logic        pop;

  sync_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK        (CLK),
    .i_Rst      (i_Rst),
    .i_Wr_DV    (i_Wr_DV),
    .i_Wr_Byte  (i_Wr_Byte),
    .i_Pop      (pop),
    .o_Rd_Byte  (o_TX_Byte),
    .o_Full     (o_Full),
    .o_Empty    (o_Empty),
    .o_Level    (o_Level),
    .o_Overflow (o_Overflow)
  );

  // Done edge register; resets high so a Done still asserted out of reset is not taken as an edge.
  always_ff @(posedge CLK) begin
    if (i_Rst) begin
      done_q <= 1'b1;
    end else begin
      done_q <= i_TX_Done;
    end
  end

  assign done_rise = i_TX_Done & ~done_q;

`ifdef UART_FEED_GAP_EN
  localparam int GW = $clog2(GAP_CLKS + 1);

  logic [GW-1:0] gap_cnt;
  logic          gap_last;

  assign gap_last = (gap_cnt == GW'(GAP_CLKS - 1));

  // Gap counter runs only while in GAP and restarts from zero on every entry.
  always_ff @(posedge CLK) begin
    if (i_Rst || (state_q != GAP)) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + GW'(1);
    end
  end
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (i_Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state: only leave IDLE when the transmitter is free, only leave WAIT_DONE on a Done edge.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:      if (!o_Empty && !i_TX_Active) state_nxt = POP;
      POP:       state_nxt = SEND;
      SEND:      state_nxt = WAIT_DONE;
`ifdef UART_FEED_GAP_EN
      WAIT_DONE: if (done_rise) state_nxt = GAP;
      GAP:       if (gap_last) state_nxt = IDLE;
`else
      WAIT_DONE: if (done_rise) state_nxt = IDLE;
`endif
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs decoded straight from the state register so the strobe is exactly one cycle.
  always_comb begin
    o_TX_DV = (state_q == SEND);
    pop     = (state_q == POP);
    o_Busy  = (state_q != IDLE);
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Byte-buffering front end that sits directly upstream of the UART transmitter. It accepts bytes from a producer into a FIFO and issues them one at a time to the transmitter over the DV/byte handshake, then waits for frame completion before issuing the next byte. It decouples bursty producers from the serial line rate.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of two, at least 2.
GAP_CLKS, 16, idle clocks inserted between frames; used only when UART_FEED_GAP_EN is defined; at least 1.

Ports:
CLK  input  1  system clock; all logic on rising edge.
i_Rst  input  1  synchronous, active-high reset.
i_Wr_DV  input  1  write strobe; one byte per cycle.
i_Wr_Byte  input  8  byte to enqueue.
o_Full  output  1  FIFO holds DEPTH bytes.
o_Empty  output  1  FIFO holds 0 bytes.
o_Level  output  $clog2(DEPTH)+1  current FIFO occupancy.
o_Overflow  output  1  one-cycle pulse when a write is dropped.
o_TX_DV  output  1  one-cycle start strobe to the transmitter.
o_TX_Byte  output  8  byte to the transmitter; valid while o_TX_DV=1, held until the next load.
i_TX_Active  input  1  transmitter busy flag.
i_TX_Done  input  1  transmitter done flag; may stay high for 2 cycles.
o_Busy  output  1  FSM not in IDLE.

Behaviour:
- Reset: FIFO pointers and o_Level go to 0; FSM goes to IDLE; o_TX_DV=0, o_TX_Byte=0x00, o_Overflow=0, o_Full=0, o_Empty=1, o_Busy=0, gap counter=0. The Done-edge register resets to 1.
- FIFO write: a write is accepted when i_Wr_DV=1 and o_Full=0. When i_Wr_DV=1 and o_Full=1, the byte is dropped and o_Overflow pulses on the next cycle.
- Simultaneous write and pop are legal when the FIFO is not full; o_Level is unchanged. Pointers wrap modulo DEPTH. o_Level is an exact count, 0..DEPTH.
- Done detection: done_rise = i_TX_Done AND NOT done_q, where done_q is i_TX_Done registered. Completion means only a rising edge, so a multi-cycle Done counts once.
- FSM states: IDLE, POP, SEND, WAIT_DONE, plus GAP when the optional feature is enabled.
  - IDLE: move to POP when o_Empty=0 and i_TX_Active=0.
  - POP: read the FIFO head into o_TX_Byte, decrement occupancy, move to SEND.
  - SEND: o_TX_DV=1 for exactly this cycle (decoded from the state register), move to WAIT_DONE.
  - WAIT_DONE: on done_rise, move to GAP if enabled, otherwise IDLE.
  - GAP: count GAP_CLKS cycles, then move to IDLE.
- Latency: a write accepted at edge N into an empty FIFO, with the FSM in IDLE and i_TX_Active=0, gives o_TX_DV=1 in the cycle after edge N+2.
- Back-to-back issue: the next o_TX_DV occurs at the earliest 3 cycles after done_rise. The transmitter is then in IDLE, because its Active flag drops together with Done.
- Reset mid-frame: the transmitter is not reset and finishes its frame. The feeder stays in IDLE until i_TX_Active=0, so no strobe is lost. The stale Done edge is ignored because it arrives while the FSM is in IDLE.
- No timeout in WAIT_DONE: a transmitter that never completes stalls the feeder. Writes continue to be accepted until the FIFO is full.

Optional Feature:
UART_FEED_GAP_EN
- Defined: the GAP state is present and adds GAP_CLKS idle cycles after each done_rise before the next pop, giving extra stop time for slow receivers.
- Undefined: there is no GAP state and no counter, and WAIT_DONE goes directly to IDLE. GAP_CLKS is ignored.

Decomposition:
- Package uart_feed_pkg holds:
  - the state enum (IDLE, POP, SEND, WAIT_DONE, GAP);
  - localparam BYTE_W=8;
  - a function for the pointer width derived from DEPTH.
- Sub-module sync_byte_fifo (DEPTH parameter; write, pop, registered read data, full, empty, level). The feeder instantiates it and holds only the FSM, the edge detector and the gap counter.

Test Plan:
1. After reset, write 0xA5 once -> o_TX_DV is high for exactly 1 cycle, 2 cycles after the write edge, with o_TX_Byte=0xA5; o_Level returns to 0.
2. Write 0x11, 0x22, 0x33 on consecutive cycles, with the transmitter model at CLKS_PER_BIT=4 -> three 10-bit frames appear on the serial line in order, with exactly 3 DV pulses, each following a Done rising edge.
3. Hold i_TX_Active=1 and write 17 bytes -> o_Full=1 at o_Level=16; the 17th byte is dropped with a 1-cycle o_Overflow pulse; o_Level stays at 16.
4. Hold i_TX_Done high for 2 cycles with 2 bytes queued -> exactly one completion is registered; the second DV does not occur before the next Done edge.
5. Assert i_Rst while a frame is active (i_TX_Active=1) with 3 bytes queued -> o_Level=0 and no DV pulse; after a new write, DV fires only once i_TX_Active=0.
6. With UART_FEED_GAP_EN defined and GAP_CLKS=5, send 2 bytes -> the second DV occurs 5+3 cycles after the first Done rising edge.
